// File: rtl/mux_gate_seq.sv
// Bit-serial logic-op sequencer: one shared 2:1 mux evaluates an operand pair
// LSB first. The mux is steered by operand A and fed constants or B by op code.
module mux_gate_seq #(
  parameter int WIDTH = 8,
  parameter int CW    = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [WIDTH-1:0] y
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sr_q, sr_d, y_q, y_d;
  logic [2:0]       op_q, op_d;
  logic             err_q, err_d;
  logic             mux_i0, mux_i1, bit_res;

  // Data-input configuration of the shared mux for the captured op.
  always_comb begin
    mux_i0 = 1'b0;
    mux_i1 = 1'b0;
    case (op_q)
      3'b000:  begin mux_i0 = 1'b0;   mux_i1 = b_q[0];  end
      3'b001:  begin mux_i0 = b_q[0]; mux_i1 = 1'b1;    end
      3'b010:  begin mux_i0 = 1'b1;   mux_i1 = ~b_q[0]; end
      3'b011:  begin mux_i0 = ~b_q[0]; mux_i1 = 1'b0;   end
      3'b100:  begin mux_i0 = b_q[0]; mux_i1 = ~b_q[0]; end
      3'b101:  begin mux_i0 = ~b_q[0]; mux_i1 = b_q[0]; end
      3'b110:  begin mux_i0 = 1'b1;   mux_i1 = 1'b0;    end
      default: begin mux_i0 = 1'b0;   mux_i1 = 1'b0;    end
    endcase
  end

  // The single mux cell; operand A's current bit is the select.
  assign bit_res = a_q[0] ? mux_i1 : mux_i0;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    sr_d    = sr_q;
    y_d     = y_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (op == 3'b111) begin
            state_d = S_DONE;
            err_d   = 1'b1;
            y_d     = '0;
          end else begin
            state_d = S_RUN;
            a_d     = a;
            b_d     = b;
            op_d    = op;
            cnt_d   = '0;
          end
        end
      end
      S_RUN: begin
        // Operands shift right so bit[counter] always sits at position 0.
        a_d  = a_q >> 1;
        b_d  = b_q >> 1;
        sr_d = {bit_res, sr_q[WIDTH-1:1]};
        if (cnt_q == LAST) begin
          y_d     = {bit_res, sr_q[WIDTH-1:1]};
          err_d   = 1'b0;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      sr_q    <= '0;
      y_q     <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      sr_q    <= sr_d;
      y_q     <= y_d;
      err_q   <= err_d;
    end
  end

  assign busy = (state_q != S_IDLE);
  assign done = (state_q == S_DONE);
  assign err  = err_q;
  assign y    = y_q;

endmodule

// File: tb/tb_mux_gate_seq.sv
// Self-checking bench for mux_gate_seq: vector table, hand sequences for
// start-hold and async reset, then random ops against a behavioural model.
module tb_mux_gate_seq;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [2:0]   op = '0;
  logic [W-1:0] a = '0, b = '0;
  logic         busy, done, err;
  logic [W-1:0] y;

  int n_chk = 0;
  int n_fail = 0;

  mux_gate_seq #(.WIDTH(W), .CW(5)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .err(err), .y(y)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] exp_y;
    logic         exp_err;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference behaviour straight from the gate truth tables.
  task automatic ref_op(input logic [2:0] o, input logic [W-1:0] av, input logic [W-1:0] bv,
                        output logic [W-1:0] ry, output logic rerr);
    rerr = 1'b0;
    case (o)
      3'd0: ry = av & bv;
      3'd1: ry = av | bv;
      3'd2: ry = ~(av & bv);
      3'd3: ry = ~(av | bv);
      3'd4: ry = av ^ bv;
      3'd5: ry = ~(av ^ bv);
      3'd6: ry = ~av;
      default: begin ry = '0; rerr = 1'b1; end
    endcase
  endtask

  // Issue one op from IDLE; lat = edges after the accept edge until done is seen.
  task automatic do_op(input string tag, input logic [2:0] o, input logic [W-1:0] av,
                       input logic [W-1:0] bv, input logic [W-1:0] ey, input logic ee);
    logic [W-1:0] y_prev;
    int lat, busy_cnt;
    bit stable;
    y_prev = y;
    stable = 1'b1;
    @(negedge clk);
    start = 1'b1; op = o; a = av; b = bv;
    @(posedge clk); #1;
    start = 1'b0; a = ~av; b = ~bv; op = 3'd7;
    lat = 0;
    busy_cnt = busy ? 1 : 0;
    while (!done && lat < 40) begin
      if (y !== y_prev) stable = 1'b0;
      @(posedge clk); #1;
      lat++;
      if (busy) busy_cnt++;
    end
    chk({tag, "_latency"}, lat, (o == 3'd7) ? 0 : W);
    chk({tag, "_busy_cycles"}, busy_cnt, (o == 3'd7) ? 1 : W + 1);
    chk({tag, "_y"}, y, ey);
    chk({tag, "_err"}, err, ee);
    chk({tag, "_y_stable_in_run"}, stable, 1);
    @(posedge clk); #1;
    chk({tag, "_done_one_cycle"}, {done, busy}, 2'b00);
  endtask

  vec_t vecs[$];

  initial begin
    logic [W-1:0] ry;
    logic rerr;
    int dcnt, guard;

    vecs.push_back('{3'd0, 8'hCA, 8'h0F, 8'h0A, 1'b0});
    vecs.push_back('{3'd0, 8'hA5, 8'h3C, 8'h24, 1'b0});
    vecs.push_back('{3'd1, 8'hA5, 8'h3C, 8'hBD, 1'b0});
    vecs.push_back('{3'd2, 8'hA5, 8'h3C, 8'hDB, 1'b0});
    vecs.push_back('{3'd3, 8'hA5, 8'h3C, 8'h42, 1'b0});
    vecs.push_back('{3'd4, 8'hA5, 8'h3C, 8'h99, 1'b0});
    vecs.push_back('{3'd5, 8'hA5, 8'h3C, 8'h66, 1'b0});
    vecs.push_back('{3'd6, 8'hA5, 8'h3C, 8'h5A, 1'b0});
    vecs.push_back('{3'd7, 8'hFF, 8'hFF, 8'h00, 1'b1});
    vecs.push_back('{3'd1, 8'h00, 8'h00, 8'h00, 1'b0});

    #12;
    chk("reset_outputs", {busy, done, err, y}, '0);
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    chk("idle_after_reset", {busy, done, err, y}, '0);

    foreach (vecs[i])
      do_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp_y, vecs[i].exp_err);

    // start held high with churning inputs: one accept, captured operands only.
    @(negedge clk);
    start = 1'b1; op = 3'd0; a = 8'hCA; b = 8'h0F;
    @(posedge clk);
    dcnt = 0; guard = 0;
    while (busy !== 1'b0 || guard == 0) begin
      @(negedge clk);
      if (done) dcnt++;
      op = 3'($urandom); a = 8'($urandom); b = 8'($urandom);
      guard++;
      if (guard > 40) break;
    end
    chk("hold_done_pulses", dcnt, 1);
    chk("hold_y", y, 8'h0A);
    chk("hold_err", err, 0);
    // Still in IDLE with start high: next edge must accept this XOR only.
    op = 3'd4; a = 8'hA5; b = 8'h3C;
    @(posedge clk); #1;
    chk("hold_second_accept", busy, 1);
    dcnt = 0;
    for (int c = 0; c < W + 1; c++) begin
      @(negedge clk);
      if (done) dcnt++;
      op = 3'($urandom); a = 8'($urandom); b = 8'($urandom);
    end
    start = 1'b0;
    chk("hold2_done_pulses", dcnt, 1);
    chk("hold2_y", y, 8'h99);
    repeat (3) @(negedge clk);
    chk("hold_back_idle", {busy, done}, 2'b00);

    // Async reset in the middle of an XOR (after bit index 4 is reached).
    @(negedge clk);
    start = 1'b1; op = 3'd4; a = 8'h0F; b = 8'hF0;
    @(posedge clk); #1; start = 1'b0;
    repeat (4) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("async_rst_clear", {busy, done, err, y}, '0);
    @(negedge clk); rst = 1'b0;
    dcnt = 0;
    repeat (12) begin @(negedge clk); if (done || busy) dcnt++; end
    chk("no_done_after_rst", dcnt, 0);
    do_op("nor_after_rst", 3'd3, 8'h00, 8'h00, 8'hFF, 1'b0);

    // Randomised ops against the model.
    for (int i = 0; i < 25; i++) begin
      logic [2:0] ro;
      logic [W-1:0] ra, rb;
      ro = 3'($urandom_range(0, 7));
      ra = 8'($urandom);
      rb = 8'($urandom);
      ref_op(ro, ra, rb, ry, rerr);
      do_op($sformatf("rand%0d_op%0d", i, ro), ro, ra, rb, ry, rerr);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
